// File: rtl/mby_mc_table_rsp.sv
// MC shared table responder: accepts EGR lookups, issues fixed-latency table SRAM
// reads and returns in-order responses through a credit-guarded response FIFO.
module mby_mc_table_rsp #(
  parameter int ADDR_W      = 12,
  parameter int NUM_ENTRIES = 3072,
  parameter int DATA_W      = 64,
  parameter int TAG_W       = 4,
  parameter int MEM_LAT     = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic              cclk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  input  logic              mem_gnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [15:0]       req_cnt,
  output logic [15:0]       err_cnt
);

  // The registered output slot is one of the RSP_DEPTH entries, so the array
  // behind it only needs RSP_DEPTH-1 locations.
  localparam int FIFO_D = RSP_DEPTH - 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int ENT_W  = 1 + TAG_W + DATA_W;

  logic [1:0]        rst_sync_q;
  logic              rst_i;
  logic              addr_err;
  logic              pop;
  logic              slot_load;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              fifo_wr;
  logic              wr_vld;
  logic              wr_err;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic [ENT_W-1:0]  wr_ent;
  logic [CNT_W-1:0]  credits;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [MEM_LAT-1:0] pipe_vld;
  logic [MEM_LAT-1:0] pipe_err;
  logic [TAG_W-1:0]  pipe_tag [MEM_LAT];
  logic [ENT_W-1:0]  fifo_mem [FIFO_D];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_i = rst_sync_q[1];

  assign addr_err    = 32'(req_addr) >= 32'(NUM_ENTRIES);
  assign ack         = rst_i & req_valid & (credits != '0) & (mem_gnt | addr_err);
  assign mem_rd_en   = ack & ~addr_err;
  assign mem_rd_addr = mem_rd_en ? req_addr : '0;

  // Request sideband travels alongside the SRAM read so it lines up with mem_rd_data.
  always_ff @(posedge cclk or negedge rst_i) begin
    if (!rst_i) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= ack;
      pipe_err[0] <= addr_err;
      pipe_tag[0] <= req_tag;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign wr_vld  = pipe_vld[MEM_LAT-1];
  assign wr_err  = pipe_err[MEM_LAT-1];
  assign wr_tag  = pipe_tag[MEM_LAT-1];
  assign wr_data = wr_err ? '0 : mem_rd_data;
  assign wr_ent  = {wr_err, wr_tag, wr_data};

  assign pop        = rsp_valid & rsp_ready;
  assign slot_load  = ~rsp_valid | pop;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_rd    = slot_load & ~fifo_empty;
  // An arriving entry bypasses the array when the slot is free and nothing is queued.
  assign fifo_wr    = wr_vld & ~(slot_load & fifo_empty);

  always_ff @(posedge cclk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge cclk or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rst_i) begin
    if (!rst_i) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (slot_load) begin
      if (!fifo_empty) begin
        rsp_valid                     <= 1'b1;
        {rsp_err, rsp_tag, rsp_data}  <= fifo_mem[rd_ptr];
      end else if (wr_vld) begin
        rsp_valid                     <= 1'b1;
        {rsp_err, rsp_tag, rsp_data}  <= wr_ent;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Credit comes back on the pop edge, so ack never sees rsp_ready combinationally.
  always_ff @(posedge cclk or negedge rst_i) begin
    if (!rst_i) begin
      credits <= CNT_W'(RSP_DEPTH);
    end else begin
      case ({ack, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rst_i) begin
    if (!rst_i) begin
      req_cnt <= '0;
      err_cnt <= '0;
    end else if (ack) begin
      req_cnt <= req_cnt + 16'd1;
      if (addr_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

`ifndef SYNTHESIS
  int inflight;
  always_comb begin
    inflight = 0;
    for (int i = 0; i < MEM_LAT; i++) inflight += int'(pipe_vld[i]);
  end

  credit_balance_a: assert property (@(posedge cclk) disable iff (!rst_i)
    (int'(fifo_cnt) + int'(rsp_valid) + inflight + int'(credits) == RSP_DEPTH));
`endif

endmodule

// File: tb/tb_mby_mc_table_rsp.sv
// Randomized and directed bench for mby_mc_table_rsp, scored against an in-order
// response queue model with credit accounting derived from outstanding requests.
module tb_mby_mc_table_rsp;
  localparam int ADDR_W      = 12;
  localparam int NUM_ENTRIES = 3072;
  localparam int DATA_W      = 64;
  localparam int TAG_W       = 4;
  localparam int MEM_LAT     = 2;
  localparam int RSP_DEPTH   = 4;

  logic              cclk        = 1'b0;
  logic              rst_n       = 1'b0;
  logic              req_valid   = 1'b0;
  logic [ADDR_W-1:0] req_addr    = '0;
  logic [TAG_W-1:0]  req_tag     = '0;
  logic              rsp_ready   = 1'b0;
  logic              mem_gnt     = 1'b0;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              ack;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [15:0]       req_cnt;
  logic [15:0]       err_cnt;

  always #5 cclk = ~cclk;

  mby_mc_table_rsp #(
    .ADDR_W(ADDR_W), .NUM_ENTRIES(NUM_ENTRIES), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .MEM_LAT(MEM_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .cclk(cclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .mem_gnt(mem_gnt), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .req_cnt(req_cnt), .err_cnt(err_cnt)
  );

  function automatic logic [63:0] mem_val(input logic [11:0] a);
    if (a == 12'h010) return 64'h0000_0000_DEAD_BEEF;
    return {a, 20'hC0FFE, a ^ 12'h5A5, 8'h3C, a};
  endfunction

  // Table SRAM: data for a read strobed in cycle T appears in cycle T+2; garbage otherwise.
  logic        rd_s   = 1'b0;
  logic [11:0] addr_s = '0;
  logic [63:0] md1    = '0;
  always @(negedge cclk) begin
    rd_s   <= mem_rd_en;
    addr_s <= mem_rd_addr;
  end
  always @(posedge cclk) begin
    md1         <= rd_s ? mem_val(addr_s) : {$urandom, $urandom};
    mem_rd_data <= md1;
  end

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    logic        err;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] m_req  = '0;
  logic [15:0] m_err  = '0;
  logic        last_ack = 1'b0;

  logic        drv_valid = 1'b0;
  logic [11:0] drv_addr  = '0;
  logic [3:0]  drv_tag   = '0;
  logic        drv_gnt   = 1'b1;
  logic        drv_ready = 1'b1;

  task automatic chk_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic err_req;
    logic e_ack;
    logic e_rv;
    exp_t e;
    @(posedge cclk);
    #1;
    req_valid = drv_valid;
    req_addr  = drv_addr;
    req_tag   = drv_tag;
    mem_gnt   = drv_gnt;
    rsp_ready = drv_ready;
    @(negedge cclk);
    cyc++;
    err_req = (drv_addr >= 12'(NUM_ENTRIES));
    e_ack   = drv_valid && (q.size() < RSP_DEPTH) && (drv_gnt || err_req);
    chk_eq("ack", 64'(ack), 64'(e_ack));
    chk_eq("mem_rd_en", 64'(mem_rd_en), 64'(e_ack && !err_req));
    if (e_ack && !err_req) chk_eq("mem_rd_addr", 64'(mem_rd_addr), 64'(drv_addr));
    chk_eq("req_cnt", 64'(req_cnt), 64'(m_req));
    chk_eq("err_cnt", 64'(err_cnt), 64'(m_err));
    e_rv = (q.size() > 0) && (cyc >= q[0].rdy);
    chk_eq("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    if (e_rv && rsp_valid) begin
      chk_eq("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
      chk_eq("rsp_data", rsp_data, q[0].data);
      chk_eq("rsp_err", 64'(rsp_err), 64'(q[0].err));
      if (drv_ready) void'(q.pop_front());
    end
    if (ack) begin
      e.tag  = drv_tag;
      e.data = err_req ? 64'd0 : mem_val(drv_addr);
      e.err  = err_req;
      e.rdy  = cyc + MEM_LAT + 1;
      q.push_back(e);
      m_req = m_req + 16'd1;
      if (err_req && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
    last_ack = ack;
  endtask

  task automatic do_reset();
    @(posedge cclk);
    #1;
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    req_valid = 1'b0;
    @(negedge cclk);
    cyc++;
    chk_eq("rst_ack", 64'(ack), 64'd0);
    chk_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk_eq("rst_rsp_data", rsp_data, 64'd0);
    chk_eq("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk_eq("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk_eq("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk_eq("rst_req_cnt", 64'(req_cnt), 64'd0);
    chk_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    q.delete();
    m_req    = '0;
    m_err    = '0;
    last_ack = 1'b0;
    rst_n    = 1'b1;
    repeat (3) step();
  endtask

  task automatic send_req(input logic [11:0] addr, input logic [3:0] tag, input int bound,
                          output int used);
    logic got;
    got       = 1'b0;
    used      = 0;
    drv_valid = 1'b1;
    drv_addr  = addr;
    drv_tag   = tag;
    while (!got && used < bound) begin
      step();
      used++;
      got = last_ack;
    end
    chk_eq("ack_wait", 64'(got), 64'd1);
  endtask

  task automatic drain(input int bound);
    int n;
    n         = 0;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    while (q.size() > 0 && n < bound) begin
      step();
      n++;
    end
    chk_eq("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic directed_single(input logic [11:0] addr, input logic [3:0] tag,
                                 input logic gnt, input logic [63:0] edata, input logic eerr);
    drv_ready = 1'b1;
    drv_gnt   = gnt;
    drv_valid = 1'b1;
    drv_addr  = addr;
    drv_tag   = tag;
    step();
    chk_eq("single_ack", 64'(ack), 64'd1);
    chk_eq("single_rd_en", 64'(mem_rd_en), 64'(!eerr));
    drv_valid = 1'b0;
    step();
    step();
    chk_eq("single_early", 64'(rsp_valid), 64'd0);
    step();
    chk_eq("single_valid", 64'(rsp_valid), 64'd1);
    chk_eq("single_data", rsp_data, edata);
    chk_eq("single_tag", 64'(rsp_tag), 64'(tag));
    chk_eq("single_err", 64'(rsp_err), 64'(eerr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1);
  end

  initial begin
    int used;
    int total;
    int cnt_a;
    int cnt_r;

    do_reset();

    directed_single(12'h010, 4'd3, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0);
    step();
    chk_eq("single_req_cnt", 64'(req_cnt), 64'd1);
    directed_single(12'd3072, 4'd5, 1'b0, 64'd0, 1'b1);
    step();
    chk_eq("oor_err_cnt", 64'(err_cnt), 64'd1);
    drv_gnt = 1'b1;

    // Backpressure: four credits, then the fifth request must stall.
    drv_ready = 1'b0;
    total = 0;
    for (int t = 0; t < 4; t++) begin
      send_req(12'(100 + t), 4'(t), 4, used);
      total += used;
    end
    chk_eq("bp_first4_cycles", 64'(total), 64'd4);
    drv_valid = 1'b1;
    drv_addr  = 12'd104;
    drv_tag   = 4'd4;
    cnt_a = 0;
    repeat (5) begin
      step();
      cnt_a += int'(last_ack);
    end
    chk_eq("bp_stall_acks", 64'(cnt_a), 64'd0);
    drv_ready = 1'b1;
    send_req(12'd104, 4'd4, 20, used);
    send_req(12'd105, 4'd5, 20, used);
    drain(50);

    // Grant stall on a valid index.
    drv_gnt   = 1'b0;
    drv_valid = 1'b1;
    drv_addr  = 12'h200;
    drv_tag   = 4'd7;
    cnt_a = 0;
    cnt_r = 0;
    repeat (5) begin
      step();
      cnt_a += int'(ack);
      cnt_r += int'(mem_rd_en);
    end
    chk_eq("gnt_stall_acks", 64'(cnt_a), 64'd0);
    chk_eq("gnt_stall_rd", 64'(cnt_r), 64'd0);
    drv_gnt = 1'b1;
    step();
    chk_eq("gnt_rise_ack", 64'(ack), 64'd1);
    chk_eq("gnt_rise_rd", 64'(mem_rd_en), 64'd1);
    drain(50);

    // Random traffic with held requests, random grant and backpressure.
    for (int i = 0; i < 3000; i++) begin
      if (!drv_valid || last_ack) begin
        drv_valid = ($urandom_range(0, 3) != 0);
        drv_addr  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(3072, 4095))
                                                : 12'($urandom_range(0, 3071));
        drv_tag   = 4'($urandom_range(0, 15));
      end
      drv_gnt   = ($urandom_range(0, 9) < 7);
      drv_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drv_gnt = 1'b1;
    drain(100);

    // Reset with responses in flight.
    drv_ready = 1'b0;
    for (int t = 0; t < 3; t++) send_req(12'(300 + t), 4'(t), 4, used);
    do_reset();
    repeat (4) step();
    total = 0;
    for (int t = 0; t < 4; t++) begin
      send_req(12'(400 + t), 4'(8 + t), 4, used);
      total += used;
    end
    chk_eq("post_rst_4_cycles", 64'(total), 64'd4);
    drain(50);

    // Full-rate streaming.
    do_reset();
    drv_ready = 1'b1;
    drv_gnt   = 1'b1;
    total = 0;
    for (int i = 0; i < 32; i++) begin
      send_req(12'($urandom_range(0, 3071)), 4'(i), 8, used);
      total += used;
    end
    chk_eq("full_rate_cycles", 64'(total), 64'd32);
    drain(20);
    chk_eq("full_rate_req_cnt", 64'(req_cnt), 64'd32);

    // err_cnt saturation; req_cnt wraps after 65536 accepts.
    do_reset();
    drv_gnt   = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send_req(12'(3072 + (i % 1024)), 4'(i), 8, used);
    drain(20);
    chk_eq("err_cnt_max", 64'(err_cnt), 64'hFFFF);
    send_req(12'd4095, 4'd9, 8, used);
    drain(20);
    chk_eq("err_cnt_sat", 64'(err_cnt), 64'hFFFF);
    chk_eq("req_cnt_wrap", 64'(req_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
